// File: rtl/simt_mask_stack_pkg.sv
// Shared SIMT stack types and default sizing.
package gpu_simt_pkg;

    localparam int LANES       = 32;
    localparam int PC_W        = 32;
    localparam int STACK_DEPTH = 64;

    // One divergence record: lanes to run, where they rejoin, where they resume.
    typedef struct packed {
        logic [LANES-1:0] mask;
        logic [PC_W-1:0]  rpc;
        logic [PC_W-1:0]  npc;
    } simt_entry_t;

    localparam logic [LANES-1:0] ALL_LANES = '1;

endpackage

// File: rtl/simt_mask_stack_if.sv
// Branch-unit <-> mask-stack bundle: push/pop requests in, top entry and status out.
interface simt_mask_stack_if #(
    parameter int LANES = gpu_simt_pkg::LANES,
    parameter int PC_W  = gpu_simt_pkg::PC_W,
    parameter int DEPTH = gpu_simt_pkg::STACK_DEPTH
);
    logic                     push_en;
    logic                     pop_en;
    logic [LANES-1:0]         push_mask;
    logic [PC_W-1:0]          push_rpc;
    logic [PC_W-1:0]          push_npc;
    logic [PC_W-1:0]          cur_pc;
    logic [LANES-1:0]         top_mask;
    logic [PC_W-1:0]          top_rpc;
    logic [PC_W-1:0]          top_npc;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     reconv;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push_en, pop_en, push_mask, push_rpc, push_npc, cur_pc,
        input  top_mask, top_rpc, top_npc, count, empty, full, reconv, overflow, underflow
    );

    modport slave (
        input  push_en, pop_en, push_mask, push_rpc, push_npc, cur_pc,
        output top_mask, top_rpc, top_npc, count, empty, full, reconv, overflow, underflow
    );
endinterface

// File: rtl/simt_mask_stack_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module simt_stack_ram #(
    parameter int  DEPTH = 64,
    parameter int  WIDTH = 96,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/simt_mask_stack.sv
// Per-warp divergence stack: count/flag control around a register-file entry store.
module simt_mask_stack
    import gpu_simt_pkg::*;
#(
    parameter int LANES       = gpu_simt_pkg::LANES,
    parameter int DEPTH       = gpu_simt_pkg::STACK_DEPTH,
    parameter int PC_W        = gpu_simt_pkg::PC_W,
    parameter int AUTO_RECONV = 1
) (
    input  logic              clk,
    input  logic              rst,
    simt_mask_stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = LANES + 2 * PC_W;

    logic [CW-1:0]    count_q, count_d;
    logic             reconv_q, reconv_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             is_empty, is_full, auto_hit, eff_pop;
    logic             we;
    logic [AW-1:0]    waddr, top_idx;
    logic [EW-1:0]    wdata, rdata;
    logic [LANES-1:0] rd_mask;
    logic [PC_W-1:0]  rd_rpc, rd_npc;

    assign top_idx  = AW'(count_q - CW'(1));
    assign {rd_mask, rd_rpc, rd_npc} = rdata;
    assign wdata    = {bus.push_mask, bus.push_rpc, bus.push_npc};
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    // Auto-pop looks at real storage only, so it can never fire on an empty stack.
    assign auto_hit = (AUTO_RECONV != 0) && !is_empty && (bus.cur_pc == rd_rpc);
    assign eff_pop  = bus.pop_en | auto_hit;

    // Decide write, new count and flag updates from push/pop and occupancy.
    always_comb begin
        we       = 1'b0;
        waddr    = count_q[AW-1:0];
        count_d  = count_q;
        reconv_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.push_en && eff_pop) begin
            if (!is_empty) begin
                // Replace top in place; legal even when full.
                we       = 1'b1;
                waddr    = top_idx;
                reconv_d = 1'b1;
            end else begin
                we      = 1'b1;
                count_d = count_q + CW'(1);
                udf_d   = 1'b1;
            end
        end else if (bus.push_en) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                count_d = count_q + CW'(1);
            end
        end else if (eff_pop) begin
            if (!is_empty) begin
                count_d  = count_q - CW'(1);
                reconv_d = 1'b1;
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    // Status registers; reset drops every entry and clears the sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            reconv_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reconv_q <= reconv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    simt_stack_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
        .clk     (clk),
        .we_i    (we & ~rst),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

    assign bus.top_mask  = is_empty ? '1 : rd_mask;
    assign bus.top_rpc   = is_empty ? '0 : rd_rpc;
    assign bus.top_npc   = is_empty ? '0 : rd_npc;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.reconv    = reconv_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_simt_mask_stack.sv
// Directed bench for simt_mask_stack with a queue-based reference model.
module tb_simt_mask_stack;
    import gpu_simt_pkg::*;

    localparam int TL = 32;
    localparam int TP = 32;
    localparam int TD = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simt_mask_stack_if #(.LANES(TL), .PC_W(TP), .DEPTH(TD)) sif ();

    simt_mask_stack #(.LANES(TL), .DEPTH(TD), .PC_W(TP), .AUTO_RECONV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    simt_entry_t mq[$];
    bit m_reconv, m_ovf, m_udf;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a LIFO of entries updated from the inputs seen at each edge.
    always @(posedge clk) begin
        simt_entry_t e;
        bit pop;
        if (rst) begin
            mq.delete();
            m_reconv = 0;
            m_ovf    = 0;
            m_udf    = 0;
            model_on = 1;
        end else if (model_on) begin
            e   = {sif.push_mask, sif.push_rpc, sif.push_npc};
            pop = sif.pop_en || (mq.size() != 0 && sif.cur_pc == mq[$].rpc);
            m_reconv = 0;
            if (sif.push_en && pop && mq.size() != 0) begin
                mq[mq.size()-1] = e;
                m_reconv = 1;
            end else if (sif.push_en) begin
                if (pop) m_udf = 1;
                if (mq.size() == TD) m_ovf = 1;
                else mq.push_back(e);
            end else if (pop) begin
                if (mq.size() != 0) begin
                    void'(mq.pop_back());
                    m_reconv = 1;
                end else begin
                    m_udf = 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_count",     64'(sif.count),     64'(mq.size()));
            chk("m_empty",     64'(sif.empty),     64'(mq.size() == 0));
            chk("m_full",      64'(sif.full),      64'(mq.size() == TD));
            chk("m_top_mask",  64'(sif.top_mask),  64'(mq.size() != 0 ? mq[$].mask : ALL_LANES));
            chk("m_top_rpc",   64'(sif.top_rpc),   64'(mq.size() != 0 ? mq[$].rpc : 32'h0));
            chk("m_top_npc",   64'(sif.top_npc),   64'(mq.size() != 0 ? mq[$].npc : 32'h0));
            chk("m_reconv",    64'(sif.reconv),    64'(m_reconv));
            chk("m_overflow",  64'(sif.overflow),  64'(m_ovf));
            chk("m_underflow", 64'(sif.underflow), 64'(m_udf));
        end
    end

    task automatic cyc(input bit p, input bit q, input logic [31:0] m,
                       input logic [31:0] r, input logic [31:0] n);
        sif.push_en   = p;
        sif.pop_en    = q;
        sif.push_mask = m;
        sif.push_rpc  = r;
        sif.push_npc  = n;
        @(posedge clk);
        #1;
        sif.push_en = 1'b0;
        sif.pop_en  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        sif.push_en   = 1'b0;
        sif.pop_en    = 1'b0;
        sif.push_mask = '0;
        sif.push_rpc  = '0;
        sif.push_npc  = '0;
        sif.cur_pc    = 32'h100;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_count",    64'(sif.count),    64'd0);
        chk("rst_empty",    64'(sif.empty),    64'd1);
        chk("rst_top_mask", 64'(sif.top_mask), 64'hFFFF_FFFF);
        chk("rst_top_rpc",  64'(sif.top_rpc),  64'd0);
        chk("rst_reconv",   64'(sif.reconv),   64'd0);

        // Two pushes
        cyc(1, 0, 32'h0000_FFFF, 32'h200, 32'h104);
        cyc(1, 0, 32'h0000_00FF, 32'h180, 32'h108);
        chk("push2_count", 64'(sif.count),    64'd2);
        chk("push2_mask",  64'(sif.top_mask), 64'h0000_00FF);
        chk("push2_npc",   64'(sif.top_npc),  64'h108);

        // Auto reconvergence at cur_pc == top_rpc
        sif.cur_pc = 32'h180;
        cyc(0, 0, 0, 0, 0);
        sif.cur_pc = 32'h100;
        chk("auto_count",  64'(sif.count),    64'd1);
        chk("auto_mask",   64'(sif.top_mask), 64'h0000_FFFF);
        chk("auto_reconv", 64'(sif.reconv),   64'd1);
        cyc(0, 0, 0, 0, 0);
        chk("auto_reconv_drop", 64'(sif.reconv), 64'd0);
        chk("auto_count_hold",  64'(sif.count),  64'd1);

        // Push and pop together replaces top
        cyc(1, 1, 32'h0000_F0F0, 32'h300, 32'h204);
        chk("repl_count",  64'(sif.count),    64'd1);
        chk("repl_mask",   64'(sif.top_mask), 64'h0000_F0F0);
        chk("repl_rpc",    64'(sif.top_rpc),  64'h300);
        chk("repl_reconv", 64'(sif.reconv),   64'd1);

        // Fill to depth, then one push too many
        for (int i = 1; i < TD; i++) cyc(1, 0, 32'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        chk("fill_count", 64'(sif.count),    64'd64);
        chk("fill_full",  64'(sif.full),     64'd1);
        chk("fill_ovf0",  64'(sif.overflow), 64'd0);
        cyc(1, 0, 32'h0000_DEAD, 32'h5000, 32'h5004);
        chk("ovf_count", 64'(sif.count),    64'd64);
        chk("ovf_flag",  64'(sif.overflow), 64'd1);
        chk("ovf_top",   64'(sif.top_mask), 64'h3F);

        // Drain, then pop once more
        repeat (TD) cyc(0, 1, 0, 0, 0);
        chk("drain_empty", 64'(sif.empty),     64'd1);
        chk("drain_count", 64'(sif.count),     64'd0);
        chk("drain_udf0",  64'(sif.underflow), 64'd0);
        cyc(0, 1, 0, 0, 0);
        chk("udf_flag",   64'(sif.underflow), 64'd1);
        chk("udf_count",  64'(sif.count),     64'd0);
        chk("udf_reconv", 64'(sif.reconv),    64'd0);

        // Reset mid-operation wins over a push
        for (int i = 0; i < 5; i++) cyc(1, 0, 32'hA0 + 32'(i), 32'h4000 + 32'(i), 32'h6000 + 32'(i));
        chk("pre_rst_count", 64'(sif.count), 64'd5);
        rst = 1'b1;
        cyc(1, 0, 32'h0000_BEEF, 32'h7000, 32'h7004);
        rst = 1'b0;
        chk("midrst_count", 64'(sif.count),     64'd0);
        chk("midrst_ovf",   64'(sif.overflow),  64'd0);
        chk("midrst_udf",   64'(sif.underflow), 64'd0);
        chk("midrst_mask",  64'(sif.top_mask),  64'hFFFF_FFFF);
        chk("midrst_empty", 64'(sif.empty),     64'd1);
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_count", 64'(sif.count), 64'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
